// File: rtl/trig_series_pkg.sv
// trig_series shared types and constants.
// Holds the FSM states, mode codes and reciprocal generator.
package trig_series_pkg;

   typedef enum logic [2:0] {
      IDLE,
      SQ,
      MX,
      MR,
      CHK,
      DONE
   } state_t;

   localparam logic MODE_COS = 1'b0;
   localparam logic MODE_SIN = 1'b1;

   // round(2^frac / d), where d is the divisor that turns
   // term k into term k+1 of the cos or sin series
   function automatic int unsigned recip_val(
      input int   frac,
      input logic mode,
      input int   k
   );
      int unsigned d;
      int unsigned a;
      int unsigned b;
      if (mode == MODE_SIN) begin
         a = 2 * k + 2;
         b = 2 * k + 3;
      end else begin
         a = 2 * k + 1;
         b = 2 * k + 2;
      end
      d = a * b;
      return ((32'd1 << frac) * 2 + d) / (2 * d);
   endfunction

endpackage

// File: rtl/trig_recip_rom.sv
// Reciprocal table for the series recurrence.
// Purely combinational; entries are elaboration-time constants.
module trig_recip_rom
   import trig_series_pkg::*;
#(
   parameter int FRAC      = 8,
   parameter int MAX_TERMS = 6
) (
   input  logic            mode,
   input  logic [3:0]      k,
   output logic [FRAC-1:0] r
);

   logic [FRAC-1:0] tab_cos [16];
   logic [FRAC-1:0] tab_sin [16];

   for (genvar i = 0; i < 16; i++) begin : g_tab
      if (i < MAX_TERMS - 1) begin : g_used
         assign tab_cos[i] = FRAC'(recip_val(FRAC, MODE_COS, i));
         assign tab_sin[i] = FRAC'(recip_val(FRAC, MODE_SIN, i));
      end else begin : g_zero
         assign tab_cos[i] = '0;
         assign tab_sin[i] = '0;
      end
   end

   // select the entry for the current term and mode
   always_comb begin
      r = tab_cos[k];
      if (mode == MODE_SIN) begin
         r = tab_sin[k];
      end
   end

endmodule

// File: rtl/trig_series.sv
// Iterative Taylor-series cos/sin in fixed point.
// One shared multiplier, early stop on small terms.
module trig_series
   import trig_series_pkg::*;
#(
   parameter int FRAC      = 8,
   parameter int INT       = 2,
   parameter int MAX_TERMS = 6,
   localparam int W        = INT + FRAC
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic            mode,
   input  logic [W-1:0]    x,
   input  logic [FRAC-1:0] eps,
   input  logic            ready,
   output logic            busy,
   output logic            done,
   output logic [W-1:0]    result,
   output logic [3:0]      terms
);

   localparam int TW  = W + FRAC;
   localparam int TW1 = TW + 1;
   localparam int MW  = 2 * W + FRAC;

   localparam logic [3:0] K_LAST = 4'(MAX_TERMS - 1);

   localparam logic signed [TW:0] SUM_MAX =
      TW1'(2 ** (W - 1) - 1);
   localparam logic signed [TW:0] SUM_MIN = ~SUM_MAX;

   localparam logic [W-1:0] ACC_MAX =
      {1'b0, {(W-1){1'b1}}};
   localparam logic [W-1:0] ACC_MIN =
      {1'b1, {(W-1){1'b0}}};
   localparam logic [W-1:0] ACC_ONE =
      (INT >= 2) ? W'(1 << FRAC) : ACC_MAX;
   localparam logic [TW-1:0] T_ONE = TW'(1 << FRAC);

   state_t state;

   logic [W-1:0]         x_r;
   logic                 mode_r;
   logic [FRAC-1:0]      eps_r;
   logic signed [TW-1:0] t;
   logic [TW-1:0]        x2;
   logic signed [W-1:0]  acc;
   logic [3:0]           k;

   logic [FRAC-1:0]      r;
   logic signed [MW-1:0] op_a;
   logic signed [MW-1:0] op_b;
   logic signed [MW-1:0] prod;
   logic signed [MW-1:0] sh;
   logic [TW-1:0]        sh_lo;
   logic [TW-1:0]        neg_lo;
   logic [TW-1:0]        abs_t;
   logic signed [TW:0]   sum;
   logic [W-1:0]         acc_sat;
   logic                 stop;
   logic [3:0]           k_inc;
   logic [TW-1:0]        t_init;
   logic [W-1:0]         acc_init;
   logic                 unused_hi;

   trig_recip_rom #(
      .FRAC      (FRAC),
      .MAX_TERMS (MAX_TERMS)
   ) u_rom (
      .mode (mode_r),
      .k    (k),
      .r    (r)
   );

   // operand select for the single shared multiplier
   always_comb begin
      op_a = '0;
      op_b = '0;
      unique case (state)
         SQ: begin
            op_a = {{(MW-W){1'b0}}, x_r};
            op_b = {{(MW-W){1'b0}}, x_r};
         end
         MX: begin
            op_a = {{(MW-TW){t[TW-1]}}, t};
            op_b = {{(MW-TW){1'b0}}, x2};
         end
         MR: begin
            op_a = {{(MW-TW){t[TW-1]}}, t};
            op_b = {{(MW-FRAC){1'b0}}, r};
         end
         default: begin
            op_a = '0;
            op_b = '0;
         end
      endcase
   end

   assign prod      = op_a * op_b;
   assign sh        = prod >>> FRAC;
   assign sh_lo     = sh[TW-1:0];
   assign neg_lo    = -sh_lo;
   assign unused_hi = ^sh[MW-1:TW];

   assign abs_t = t[TW-1] ? -t : t;
   assign stop  = abs_t < {{(TW-FRAC){1'b0}}, eps_r};
   assign k_inc = k + 4'd1;

   assign sum = $signed({t[TW-1], t})
              + $signed({{(TW1-W){acc[W-1]}}, acc});

   // clamp the running sum into the result range
   always_comb begin
      acc_sat = sum[W-1:0];
      if (sum > SUM_MAX) begin
         acc_sat = ACC_MAX;
      end else if (sum < SUM_MIN) begin
         acc_sat = ACC_MIN;
      end
   end

   // first term: 1.0 for cos, x for sin (x clamped into acc)
   always_comb begin
      t_init   = T_ONE;
      acc_init = ACC_ONE;
      if (mode == MODE_SIN) begin
         t_init   = {{(TW-W){1'b0}}, x};
         acc_init = x[W-1] ? ACC_MAX : x;
      end
   end

   // sequencer, datapath registers and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         busy   <= 1'b0;
         done   <= 1'b0;
         result <= '0;
         terms  <= '0;
         t      <= '0;
         acc    <= '0;
         x2     <= '0;
         k      <= '0;
         x_r    <= '0;
         mode_r <= MODE_COS;
         eps_r  <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (start) begin
                  x_r    <= x;
                  mode_r <= mode;
                  eps_r  <= eps;
                  k      <= '0;
                  t      <= t_init;
                  acc    <= acc_init;
                  busy   <= 1'b1;
                  state  <= SQ;
               end
            end
            SQ: begin
               x2    <= sh_lo;
               state <= MX;
            end
            MX: begin
               t     <= sh_lo;
               state <= MR;
            end
            MR: begin
               t     <= neg_lo;
               state <= CHK;
            end
            CHK: begin
               if (stop) begin
                  state <= DONE;
               end else begin
                  acc <= acc_sat;
                  k   <= k_inc;
                  if (k_inc == K_LAST) begin
                     state <= DONE;
                  end else begin
                     state <= MX;
                  end
               end
            end
            DONE: begin
               if (done && ready) begin
                  done  <= 1'b0;
                  busy  <= 1'b0;
                  state <= IDLE;
               end else begin
                  done   <= 1'b1;
                  result <= acc;
                  terms  <= k_inc;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_trig_series.sv
// Self-checking bench for trig_series.
// Vector table, scoreboard queue and hand sequences.
module tb_trig_series;

   localparam int FRAC = 8;
   localparam int INT  = 2;
   localparam int MT   = 6;
   localparam int W    = INT + FRAC;

   logic            clk = 1'b0;
   logic            rst;
   logic            start;
   logic            mode;
   logic [W-1:0]    x;
   logic [FRAC-1:0] eps;
   logic            ready;
   logic            busy;
   logic            done;
   logic [W-1:0]    result;
   logic [3:0]      terms;

   always #5 clk = ~clk;

   trig_series #(
      .FRAC      (FRAC),
      .INT       (INT),
      .MAX_TERMS (MT)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .mode   (mode),
      .x      (x),
      .eps    (eps),
      .ready  (ready),
      .busy   (busy),
      .done   (done),
      .result (result),
      .terms  (terms)
   );

   typedef struct {
      int res;
      int terms;
      int lat;
   } exp_t;

   typedef struct {
      int x;
      bit m;
      int eps;
      int lo;
      int hi;
      int terms;
      int lat;
   } vec_t;

   exp_t sbq[$];
   vec_t tbl[9];

   int checks   = 0;
   int failures = 0;

   task automatic check(input string name,
                        input int act, input int req);
      checks++;
      if (act != req) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d",
                  name, act, req);
      end
   endtask

   task automatic check_rng(input string name, input int act,
                            input int lo, input int hi);
      checks++;
      if (act < lo || act > hi) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d..%0d",
                  name, act, lo, hi);
      end
   endtask

   function automatic int rtab(input bit m, input int k);
      int c[5];
      int s[5];
      c = '{128, 21, 9, 5, 3};
      s = '{43, 13, 6, 4, 2};
      return m ? s[k] : c[k];
   endfunction

   function automatic int sat(input int v);
      if (v > 511) return 511;
      if (v < -512) return -512;
      return v;
   endfunction

   function automatic exp_t model(input int xv, input bit m,
                                  input int ev);
      int   x2;
      int   t;
      int   acc;
      int   k;
      int   it;
      int   a;
      exp_t e;
      x2  = (xv * xv) >>> FRAC;
      t   = m ? xv : 256;
      acc = m ? sat(xv) : 256;
      k   = 0;
      it  = 0;
      while (1) begin
         t = (t * x2) >>> FRAC;
         t = -((t * rtab(m, k)) >>> FRAC);
         it++;
         a = (t < 0) ? -t : t;
         if (a < ev) break;
         acc = sat(acc + t);
         k++;
         if (k == MT - 1) break;
      end
      e.res   = acc;
      e.terms = k + 1;
      e.lat   = 2 + 3 * it;
      return e;
   endfunction

   task automatic run_job(input int xv, input bit m,
                          input int ev, input int stall,
                          input bit noise,
                          output int res, output int trm,
                          output int lat);
      int   n;
      exp_t e;
      n = 0;
      while (busy && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("idle_before_start", int'(busy), 0);
      sbq.push_back(model(xv, m, ev));
      x     = W'(xv);
      mode  = m;
      eps   = FRAC'(ev);
      start = 1'b1;
      ready = 1'b0;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      lat   = 0;
      while (!done && lat < 100) begin
         if (noise) begin
            x     = W'($urandom);
            mode  = 1'($urandom);
            eps   = FRAC'($urandom);
            ready = 1'($urandom);
            start = 1'($urandom);
         end
         @(posedge clk);
         lat++;
         @(negedge clk);
      end
      start = 1'b0;
      ready = 1'b0;
      res   = int'($signed(result));
      trm   = int'(terms);
      if (!done) begin
         check("done_timeout", 0, 1);
         void'(sbq.pop_front());
         return;
      end
      e = sbq.pop_front();
      check("sb_result", res, e.res);
      check("sb_terms", trm, e.terms);
      check("sb_latency", lat, e.lat);
      for (int i = 0; i < stall; i++) begin
         start = 1'(i % 2);
         x     = W'($urandom);
         @(posedge clk);
         @(negedge clk);
         check("stall_done", int'(done), 1);
         check("stall_result",
               int'($signed(result)), res);
         check("stall_terms", int'(terms), trm);
      end
      ready = 1'b1;
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      ready = 1'b0;
      start = 1'b0;
      check("release_busy", int'(busy), 0);
      check("release_done", int'(done), 0);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      failures++;
      $display("TB_RESULT checks=%0d failures=%0d",
               checks, failures);
      $fatal(1, "watchdog");
   end

   initial begin
      int res;
      int trm;
      int lat;
      int xv;
      int ev;
      bit m;

      tbl[0] = '{0,   0, 1,   256, 256, 1, 5};
      tbl[1] = '{256, 0, 0,   136, 140, 6, 17};
      tbl[2] = '{128, 1, 0,   121, 125, 6, 17};
      tbl[3] = '{402, 1, 0,   254, 258, 6, 17};
      tbl[4] = '{402, 0, 0,   -2,  2,   6, 17};
      tbl[5] = '{0,   1, 1,   0,   0,   1, 5};
      tbl[6] = '{256, 0, 16,  128, 128, 2, 8};
      tbl[7] = '{256, 0, 255, 256, 256, 1, 5};
      tbl[8] = '{256, 1, 0,   213, 218, 6, 17};

      rst   = 1'b1;
      start = 1'b0;
      mode  = 1'b0;
      x     = '0;
      eps   = '0;
      ready = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset_busy", int'(busy), 0);
      check("reset_done", int'(done), 0);
      check("reset_result", int'(result), 0);
      check("reset_terms", int'(terms), 0);
      rst = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 9; i++) begin
         run_job(tbl[i].x, tbl[i].m, tbl[i].eps,
                 1, 1'b0, res, trm, lat);
         check_rng("vec_result", res, tbl[i].lo, tbl[i].hi);
         check("vec_terms", trm, tbl[i].terms);
         check("vec_latency", lat, tbl[i].lat);
      end

      run_job(128, 1'b1, 0, 10, 1'b0, res, trm, lat);
      check("bp_result", res, 124);
      @(negedge clk);
      check("bp_idle_after", int'(busy), 0);

      sbq.push_back(model(256, 1'b0, 0));
      x     = W'(256);
      mode  = 1'b0;
      eps   = '0;
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      sbq.delete();
      check("midrst_busy", int'(busy), 0);
      check("midrst_done", int'(done), 0);
      check("midrst_result", int'(result), 0);
      check("midrst_terms", int'(terms), 0);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         check("midrst_no_done", int'(done), 0);
      end
      run_job(256, 1'b0, 0, 0, 1'b0, res, trm, lat);
      check("midrst_rerun", res, 139);

      for (int i = 0; i < 1000; i++) begin
         xv = int'($urandom_range(0, 402));
         m  = 1'($urandom);
         ev = ($urandom_range(0, 1) == 0)
            ? 0 : int'($urandom_range(1, 40));
         run_job(xv, m, ev, int'($urandom_range(0, 3)),
                 1'b1, res, trm, lat);
      end

      check("sb_empty", sbq.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d",
               checks, failures);
      $finish;
   end

endmodule
